tt_mux_pipe: RTL and testbench

//  Registered successor of the row mux: serves two rows of N_UM user tiles from one spine tap.

---
 rtl/tt_mux_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_tt_mux_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_pipe.sv
// Registered row-pair mux: one spine tap serves N_UM user tiles with break-before-make switching.
// Optional macro TT_MUX_IW_HOLD_EN keeps a per-tile inward hold register across deselect.
module tt_mux_pipe #(
  parameter int unsigned N_UM      = 16,
  parameter int unsigned N_IO      = 8,
  parameter int unsigned N_O       = 8,
  parameter int unsigned N_I       = 10,
  parameter int unsigned GUARD_CYC = 2,
  parameter int unsigned OW_PIPE   = 1,
  localparam int unsigned U_OW = N_O + 2 * N_IO,
  localparam int unsigned U_IW = N_I + N_IO,
  localparam int unsigned S_OW = U_OW + 2,
  localparam int unsigned S_IW = U_IW + 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [U_OW*N_UM-1:0]   um_ow_i,
  output logic [U_IW*N_UM-1:0]   um_iw_o,
  output logic [N_UM-1:0]        um_ena_o,
  output logic [N_UM-1:0]        um_k_zero_o,
  output logic [S_OW-1:0]        spine_ow_o,
  input  logic [S_IW-1:0]        spine_iw_i,
  input  logic [4:0]             addr_i,
  output logic                   busy_o,
  output logic                   k_zero_o,
  output logic                   k_one_o
);

  localparam logic [3:0] GcntLoad = (GUARD_CYC == 0) ? 4'd0 : 4'(GUARD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StGuard, StActive} state_e;

  // Spine inward fields: {gh[1:0], si_usr, si_sel[9:0], si_ld, si_ena, gl}
  logic [U_IW-1:0] si_usr;
  logic [9:0]      si_sel;
  logic            si_ld;
  logic            si_ena;
  logic            unused_guard;

  assign si_ena       = spine_iw_i[1];
  assign si_ld        = spine_iw_i[2];
  assign si_sel       = spine_iw_i[12:3];
  assign si_usr       = spine_iw_i[13 +: U_IW];
  assign unused_guard = ^{spine_iw_i[S_IW-1 -: 2], spine_iw_i[0]};

  logic       hit;
  logic [4:0] tile;
  logic       tgt_ok;

  assign hit    = (si_sel[9:6] == addr_i[4:1]) && (si_sel[4] == addr_i[0]);
  assign tile   = {si_sel[3:0], si_sel[5]};
  assign tgt_ok = hit && si_ena && ({27'd0, tile} < N_UM);

  state_e          state_q, state_d;
  logic [4:0]      cur_q, cur_d;
  logic [4:0]      pend_q, pend_d;
  logic            pend_ok_q, pend_ok_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [N_UM-1:0] ena_q, ena_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    pend_ok_d = pend_ok_q;
    gcnt_d    = gcnt_q;
    unique case (state_q)
      StIdle: begin
        if (si_ld && tgt_ok) begin
          state_d = StActive;
          cur_d   = tile;
        end
      end
      StActive: begin
        // Reloading the tile already selected must not disturb um_ena.
        if (si_ld && !(tgt_ok && (tile == cur_q))) begin
          pend_d    = tile;
          pend_ok_d = tgt_ok;
          if (GUARD_CYC == 0) begin
            if (tgt_ok) begin
              cur_d = tile;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StGuard;
            gcnt_d  = GcntLoad;
          end
        end
      end
      StGuard: begin
        if (si_ld) begin
          pend_d    = tile;
          pend_ok_d = tgt_ok;
          gcnt_d    = GcntLoad;
        end else if (gcnt_q == 4'd0) begin
          if (pend_ok_q) begin
            state_d = StActive;
            cur_d   = pend_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next state so a load is visible right after its edge.
  always_comb begin
    ena_d = '0;
    for (int k = 0; k < N_UM; k++) begin
      ena_d[k] = (state_d == StActive) && (cur_d == 5'(k));
    end
    busy_d = (state_d == StGuard);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      pend_q    <= '0;
      pend_ok_q <= 1'b0;
      gcnt_q    <= '0;
      ena_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      pend_ok_q <= pend_ok_d;
      gcnt_q    <= gcnt_d;
      ena_q     <= ena_d;
      busy_q    <= busy_d;
    end
  end

  assign um_ena_o = ena_q;
  assign busy_o   = busy_q;

`ifdef TT_MUX_IW_HOLD_EN
  logic [U_IW-1:0] hold_q [N_UM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_UM; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_UM; k++) begin
        if (ena_d[k]) begin
          hold_q[k] <= si_usr;
        end
      end
    end
  end

  always_comb begin
    um_iw_o = '0;
    for (int k = 0; k < N_UM; k++) begin
      um_iw_o[k*U_IW +: U_IW] = hold_q[k];
    end
  end
`else
  logic [U_IW-1:0] iw_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iw_q <= '0;
    end else begin
      iw_q <= (state_d == StActive) ? si_usr : '0;
    end
  end

  // One shared register, steered to the enabled tile only.
  always_comb begin
    um_iw_o = '0;
    for (int k = 0; k < N_UM; k++) begin
      if (ena_q[k]) begin
        um_iw_o[k*U_IW +: U_IW] = iw_q;
      end
    end
  end
`endif

  logic [U_OW-1:0] ow_sel;
  logic [U_OW-1:0] so_usr;

  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < N_UM; k++) begin
      if (ena_q[k]) begin
        ow_sel = um_ow_i[k*U_OW +: U_OW];
      end
    end
  end

  if (OW_PIPE != 0) begin : g_ow_reg
    logic [U_OW-1:0] so_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        so_q <= '0;
      end else begin
        so_q <= ow_sel;
      end
    end

    assign so_usr = so_q;
  end else begin : g_ow_comb
    assign so_usr = ow_sel;
  end

  assign spine_ow_o  = {1'b0, so_usr, 1'b0};
  assign um_k_zero_o = '0;
  assign k_zero_o    = 1'b0;
  assign k_one_o     = 1'b1;

endmodule

// File: tb/tb_tt_mux_pipe.sv
// Directed bench for tt_mux_pipe: vector table for tile selection plus hand-written sequences.
module tb_tt_mux_pipe;

  localparam int U_OW = 24;
  localparam int U_IW = 18;
  localparam int N_UM = 16;

  logic                  clk;
  logic                  rst_n;
  logic [U_OW*N_UM-1:0]  um_ow;
  logic [U_IW*N_UM-1:0]  um_iw;
  logic [N_UM-1:0]       um_ena;
  logic [N_UM-1:0]       um_k_zero;
  logic [U_OW+1:0]       spine_ow;
  logic [U_IW+14:0]      spine_iw;
  logic [4:0]            addr;
  logic                  busy;
  logic                  k_zero;
  logic                  k_one;

  logic [1:0]      gh;
  logic            gl;
  logic [U_IW-1:0] si_usr;
  logic [9:0]      si_sel;
  logic            si_ld;
  logic            si_ena;

  assign spine_iw = {gh, si_usr, si_sel, si_ld, si_ena, gl};

  tt_mux_pipe dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .um_ow_i     (um_ow),
    .um_iw_o     (um_iw),
    .um_ena_o    (um_ena),
    .um_k_zero_o (um_k_zero),
    .spine_ow_o  (spine_ow),
    .spine_iw_i  (spine_iw),
    .addr_i      (addr),
    .busy_o      (busy),
    .k_zero_o    (k_zero),
    .k_one_o     (k_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [4:0]  sel_addr;
    logic [4:0]  tile;
    logic        ena;
    logic        ld;
    logic [15:0] exp_ena;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk_sel(input logic [4:0] a, input logic [4:0] t);
    return {a[4:1], t[0], a[0], t[4:1]};
  endfunction

  function automatic logic [23:0] ow_val(input int k, input logic [7:0] salt);
    return {salt, 8'(k), 8'hC3 ^ 8'(k)};
  endfunction

  function automatic logic [U_IW*N_UM-1:0] iw_at(input int k, input logic [U_IW-1:0] v);
    return (U_IW*N_UM)'(v) << (k * U_IW);
  endfunction

  task automatic set_ow(input logic [7:0] salt);
    for (int k = 0; k < N_UM; k++) um_ow[k*U_OW +: U_OW] = ow_val(k, salt);
  endtask

  task automatic load(input logic [4:0] a, input logic [4:0] t, input logic e);
    si_sel = mk_sel(a, t);
    si_ena = e;
    si_ld  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [4:0] a, input logic [4:0] sa, input logic [4:0] t,
                     input logic e, input logic l, input logic [15:0] xe, input logic xb);
    vec_t v;
    v.addr = a; v.sel_addr = sa; v.tile = t; v.ena = e; v.ld = l;
    v.exp_ena = xe; v.exp_busy = xb;
    vq.push_back(v);
  endtask

  logic [U_IW-1:0] last_iw3;

  initial begin
    rst_n  = 1'b0;
    gh     = 2'b11;
    gl     = 1'b1;
    si_usr = '0;
    si_sel = '0;
    si_ld  = 1'b0;
    si_ena = 1'b0;
    addr   = 5'd5;
    set_ow(8'h11);

    add(5, 5,  3, 1, 1, 16'h0008, 0);
    add(5, 5,  7, 1, 0, 16'h0008, 0);  // sel change without ld is ignored
    add(5, 5,  3, 1, 1, 16'h0008, 0);  // same tile reload
    add(5, 5,  6, 1, 1, 16'h0000, 1);
    add(5, 5,  6, 1, 0, 16'h0000, 1);
    add(5, 5,  6, 1, 0, 16'h0040, 0);
    add(5, 5, 20, 1, 1, 16'h0000, 1);  // tile >= N_UM
    add(5, 5, 20, 1, 0, 16'h0000, 1);
    add(5, 5, 20, 1, 0, 16'h0000, 0);
    add(5, 5,  5, 0, 1, 16'h0000, 0);  // ena low in IDLE
    add(5, 4,  2, 1, 1, 16'h0000, 0);  // addr[0] mismatch
    add(5, 7,  2, 1, 1, 16'h0000, 0);  // addr[4:1] mismatch
    add(5, 5, 15, 1, 1, 16'h8000, 0);
    add(5, 7, 15, 1, 1, 16'h0000, 1);  // miss while ACTIVE
    add(5, 7, 15, 1, 0, 16'h0000, 1);
    add(5, 7, 15, 1, 0, 16'h0000, 0);
    add(6, 6,  0, 1, 1, 16'h0001, 0);
    add(6, 6,  0, 0, 1, 16'h0000, 1);  // same tile but ena low
    add(6, 6,  0, 0, 0, 16'h0000, 1);
    add(6, 6,  0, 0, 0, 16'h0000, 0);
    add(6, 6,  0, 1, 1, 16'h0001, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", um_ena, 0);
    chk("rst_busy", busy, 0);
    chk("rst_iw", um_iw, 0);
    chk("rst_spine_ow", spine_ow, 0);
    chk("k_one", k_one, 1);
    chk("k_zero", k_zero, 0);
    chk("um_k_zero", um_k_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      addr   = vq[i].addr;
      si_sel = mk_sel(vq[i].sel_addr, vq[i].tile);
      si_ena = vq[i].ena;
      si_ld  = vq[i].ld;
      step();
      chk($sformatf("vec%0d_ena", i), um_ena, vq[i].exp_ena);
      chk($sformatf("vec%0d_busy", i), busy, vq[i].exp_busy);
    end

    // Switch to tile 3, then exercise inward and outward data paths.
    addr = 5'd5;
    load(5, 3, 1);
    step();
    si_ld = 1'b0;
    chk("sw3_g1_ena", um_ena, 0);
    step();
    chk("sw3_g2_busy", busy, 1);
    step();
    chk("sw3_ena", um_ena, 16'h0008);
    chk("ow_first_zero", spine_ow, 0);
    set_ow(8'hA0);
    si_usr = 18'h2A5A5;
    step();
    chk("iw_tile3", um_iw, iw_at(3, 18'h2A5A5));
    chk("ow_tile3", spine_ow, {1'b0, ow_val(3, 8'hA0), 1'b0});
    set_ow(8'h5B);
    si_usr = 18'h01234;
    #1;
    chk("ow_pipe_hold", spine_ow, {1'b0, ow_val(3, 8'hA0), 1'b0});
    step();
    chk("iw_tile3_b", um_iw, iw_at(3, 18'h01234));
    chk("ow_tile3_b", spine_ow, {1'b0, ow_val(3, 8'h5B), 1'b0});
    last_iw3 = 18'h01234;

    // ld 6 then ld 9 in the first guard cycle: guard restarts, tile 6 never enabled.
    si_usr = 18'h3FFFF;
    load(5, 6, 1);
    step();
    chk("rs_g1_ena", um_ena, 0);
    chk("rs_g1_busy", busy, 1);
`ifdef TT_MUX_IW_HOLD_EN
    chk("rs_g1_iw_hold", um_iw, iw_at(3, last_iw3));
`else
    chk("rs_g1_iw", um_iw, 0);
`endif
    load(5, 9, 1);
    step();
    si_ld = 1'b0;
    chk("rs_g2_ena", um_ena, 0);
    chk("rs_g2_ow", spine_ow, 0);
    step();
    chk("rs_g3_ena", um_ena, 0);
    chk("rs_g3_busy", busy, 1);
    step();
    chk("rs_ena9", um_ena, 16'h0200);
    chk("rs_busy9", busy, 0);

    // Reset in the middle of a guard.
    load(5, 3, 1);
    step();
    si_ld = 1'b0;
    chk("mg_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mg_rst_ena", um_ena, 0);
    chk("mg_rst_busy", busy, 0);
    chk("mg_rst_iw", um_iw, 0);
    chk("mg_rst_ow", spine_ow, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    si_usr = 18'h15A5A;
    load(5, 1, 1);
    step();
    si_ld = 1'b0;
    chk("mg_ena1", um_ena, 16'h0002);
    chk("mg_busy1", busy, 0);
    chk("mg_iw1", um_iw, iw_at(1, 18'h15A5A));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
